// File: rtl/pipe_ctrl_pkg.sv
// Shared core package: hold-level encoding, pipeline sequencer states,
// bus widths and the CPU reset vector.
package literiscv_pkg;

    localparam int InstAddrBus = 32;
    localparam int HoldFlagBus = 3;
    localparam logic [InstAddrBus-1:0] CpuResetAddr = 32'h0000_0000;

    // Pipeline hold levels; a higher value stalls more of the front end.
    typedef enum logic [HoldFlagBus-1:0] {
        HoldNone = 3'd0,
        HoldPc   = 3'd1,
        HoldIf   = 3'd2,
        HoldId   = 3'd3
    } hold_e;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALTED,
        ST_RSTSEQ
    } state_e;

    function automatic hold_e hold_max(hold_e a, hold_e b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Request/response bundle between the core stages and pipe_ctrl.
//   master : the core side (drives i_* requests, observes o_* controls)
//   slave  : pipe_ctrl itself
interface pipe_ctrl_if;
    import literiscv_pkg::*;

    logic                   i_ex_jump_flag;
    logic [InstAddrBus-1:0] i_ex_jump_addr;
    logic                   i_ex_hold_req;
    logic                   i_rib_hold_req;
    logic                   i_clint_int_flag;
    logic [InstAddrBus-1:0] i_clint_int_addr;
    logic                   i_clint_hold_req;
    logic                   i_jtag_halt_req;
    logic                   i_jtag_reset_req;
    logic [HoldFlagBus-1:0] o_hold_flag;
    logic                   o_jump_flag;
    logic [InstAddrBus-1:0] o_jump_addr;
    logic                   o_jtag_reset_flag;
    logic                   o_halted;
    logic                   o_bus_timeout;

    modport master (
        output i_ex_jump_flag, i_ex_jump_addr, i_ex_hold_req, i_rib_hold_req,
               i_clint_int_flag, i_clint_int_addr, i_clint_hold_req,
               i_jtag_halt_req, i_jtag_reset_req,
        input  o_hold_flag, o_jump_flag, o_jump_addr, o_jtag_reset_flag,
               o_halted, o_bus_timeout
    );

    modport slave (
        input  i_ex_jump_flag, i_ex_jump_addr, i_ex_hold_req, i_rib_hold_req,
               i_clint_int_flag, i_clint_int_addr, i_clint_hold_req,
               i_jtag_halt_req, i_jtag_reset_req,
        output o_hold_flag, o_jump_flag, o_jump_addr, o_jtag_reset_flag,
               o_halted, o_bus_timeout
    );

endinterface

// File: rtl/pipe_ctrl_wdog.sv
// Bus-stall watchdog: counts consecutive bus-hold cycles, saturating at
// BusTimeout, and raises a sticky timeout flag once the limit is reached.
//   i_clk, i_rst : clock, synchronous active-high reset
//   rib_hold_i   : bus-arbiter stall request
//   timeout_o    : sticky timeout flag (cleared only by i_rst)
module pipe_ctrl_wdog #(
    parameter int BusTimeout = 256
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic rib_hold_i,
    output logic timeout_o
);
    localparam int CW = $clog2(BusTimeout + 1);
    localparam logic [CW-1:0] Lim = CW'(BusTimeout);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          to_q;

    always_comb begin
        cnt_d = '0;
        if (rib_hold_i)
            cnt_d = (cnt_q == Lim) ? cnt_q : cnt_q + CW'(1);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (cnt_d == Lim)
                to_q <= 1'b1;
        end
    end

    assign timeout_o = to_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline sequencer. Merges stage hold/redirect requests into one
// hold level and one jump pair (combinational, sampled by the PC register
// on the next edge) and sequences JTAG halt / JTAG reset.
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus          : pipe_ctrl_if.slave - requests in, hold/jump/status out
module pipe_ctrl
    import literiscv_pkg::*;
#(
    parameter int RstCycles  = 4,
    parameter int BusTimeout = 256
) (
    input  logic        i_clk,
    input  logic        i_rst,
    pipe_ctrl_if.slave  bus
);
    localparam int RCW = (RstCycles > 1) ? $clog2(RstCycles) : 1;

    state_e           state_q, state_d;
    logic [RCW-1:0]   rcnt_q, rcnt_d;
    logic             halted_q, jrst_q;
    hold_e            hold_d, req_hold;
    logic             jump_d, redir_flag, stall_any;
    logic [InstAddrBus-1:0] addr_d, redir_addr;

    // Execute jump wins over the interrupt redirect.
    assign redir_flag = bus.i_ex_jump_flag | bus.i_clint_int_flag;
    assign redir_addr = bus.i_ex_jump_flag   ? bus.i_ex_jump_addr :
                        bus.i_clint_int_flag ? bus.i_clint_int_addr : '0;
    assign stall_any  = bus.i_ex_hold_req | bus.i_rib_hold_req | bus.i_clint_hold_req;

    // Any redirect must flush IF/ID, so it ranks with the stage stalls.
    assign req_hold = (bus.i_ex_hold_req | bus.i_clint_hold_req | redir_flag) ? HoldId :
                      bus.i_rib_hold_req ? HoldPc : HoldNone;

    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        hold_d  = HoldNone;
        jump_d  = 1'b0;
        addr_d  = '0;
        case (state_q)
            ST_RUN: begin
                hold_d = req_hold;
                jump_d = redir_flag;
                addr_d = redir_addr;
                if (bus.i_jtag_halt_req)
                    state_d = stall_any ? ST_DRAIN : ST_HALTED;
            end
            ST_DRAIN: begin
                // Freeze fetch while in-flight stalls finish; jumps still pass.
                hold_d = hold_max(req_hold, HoldPc);
                jump_d = redir_flag;
                addr_d = redir_addr;
                if (!bus.i_jtag_halt_req)
                    state_d = ST_RUN;
                else if (!stall_any)
                    state_d = ST_HALTED;
            end
            ST_HALTED: begin
                hold_d = HoldId;
                if (!bus.i_jtag_halt_req)
                    state_d = ST_RUN;
            end
            ST_RSTSEQ: begin
                hold_d = HoldId;
                rcnt_d = rcnt_q + RCW'(1);
                if (rcnt_q == RCW'(RstCycles - 1)) begin
                    state_d = ST_RUN;
                    rcnt_d  = '0;
                end
            end
            default: state_d = ST_RUN;
        endcase
        // Debugger reset overrides everything and restarts the sequence.
        if (bus.i_jtag_reset_req) begin
            state_d = ST_RSTSEQ;
            rcnt_d  = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_RUN;
            rcnt_q   <= '0;
            halted_q <= 1'b0;
            jrst_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rcnt_q   <= rcnt_d;
            halted_q <= (state_d == ST_HALTED);
            jrst_q   <= (state_d == ST_RSTSEQ);
        end
    end

    pipe_ctrl_wdog #(.BusTimeout(BusTimeout)) u_wdog (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .rib_hold_i (bus.i_rib_hold_req),
        .timeout_o  (bus.o_bus_timeout)
    );

    assign bus.o_hold_flag       = hold_d;
    assign bus.o_jump_flag       = jump_d;
    assign bus.o_jump_addr       = addr_d;
    assign bus.o_jtag_reset_flag = jrst_q;
    assign bus.o_halted          = halted_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: directed scenarios followed by randomized traffic,
// every cycle compared against a behavioural model of the sequencer.
module tb_pipe_ctrl;
    localparam int RST_CYC = 4;
    localparam int TMO     = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_ctrl_if bus();

    pipe_ctrl #(.RstCycles(RST_CYC), .BusTimeout(TMO)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Model: mode 0=run 1=drain 2=halted 3=jtag-reset; rst_left = reset
    // cycles still owed; wd = consecutive bus-hold cycles (saturating).
    int m_mode, m_rst_left, m_wd;
    bit m_to;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    task automatic idle_inputs();
        bus.i_ex_jump_flag   = 0; bus.i_ex_jump_addr   = '0;
        bus.i_ex_hold_req    = 0; bus.i_rib_hold_req   = 0;
        bus.i_clint_int_flag = 0; bus.i_clint_int_addr = '0;
        bus.i_clint_hold_req = 0; bus.i_jtag_halt_req  = 0;
        bus.i_jtag_reset_req = 0;
    endtask

    task automatic model_reset();
        m_mode = 0; m_rst_left = 0; m_wd = 0; m_to = 0;
    endtask

    // Check one cycle at the negedge, then advance the model at the posedge.
    task automatic tick();
        bit jr, stall;
        int eh, ej;
        logic [31:0] ea;
        @(negedge clk);
        jr    = bus.i_ex_jump_flag | bus.i_clint_int_flag;
        stall = bus.i_ex_hold_req | bus.i_rib_hold_req | bus.i_clint_hold_req;
        if (m_mode >= 2) begin
            eh = 3; ej = 0;
        end else begin
            eh = 0;
            if (bus.i_rib_hold_req) eh = 1;
            if (bus.i_ex_hold_req || bus.i_clint_hold_req || jr) eh = 3;
            if (m_mode == 1 && eh < 1) eh = 1;
            ej = jr;
        end
        ea = !ej ? 32'h0 : bus.i_ex_jump_flag ? bus.i_ex_jump_addr : bus.i_clint_int_addr;
        chk("hold",    32'(bus.o_hold_flag),      32'(eh));
        chk("jump",    32'(bus.o_jump_flag),      32'(ej));
        chk("addr",    bus.o_jump_addr,           ea);
        chk("halted",  32'(bus.o_halted),         32'(m_mode == 2));
        chk("jrst",    32'(bus.o_jtag_reset_flag), 32'(m_mode == 3));
        chk("timeout", 32'(bus.o_bus_timeout),    32'(m_to));
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            m_wd = bus.i_rib_hold_req ? ((m_wd < TMO) ? m_wd + 1 : TMO) : 0;
            if (m_wd == TMO) m_to = 1;
            if (bus.i_jtag_reset_req) begin
                m_mode = 3; m_rst_left = RST_CYC;
            end else begin
                case (m_mode)
                    0: if (bus.i_jtag_halt_req) m_mode = stall ? 1 : 2;
                    1: if (!bus.i_jtag_halt_req) m_mode = 0;
                       else if (!stall) m_mode = 2;
                    2: if (!bus.i_jtag_halt_req) m_mode = 0;
                    default: begin
                        m_rst_left--;
                        if (m_rst_left == 0) m_mode = 0;
                    end
                endcase
            end
        end
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        @(posedge clk); #1;
        model_reset();
        tick();                      // second reset cycle, now checked
        rst = 0;
        ticks(2);

        // Jump priority: ex wins over clint.
        bus.i_ex_jump_flag = 1;   bus.i_ex_jump_addr = 32'h100;
        bus.i_clint_int_flag = 1; bus.i_clint_int_addr = 32'h200;
        tick();
        bus.i_ex_jump_flag = 0;
        tick();                      // clint alone
        bus.i_clint_int_flag = 0;
        tick();

        // Halt with drain.
        bus.i_ex_hold_req = 1;
        tick();
        bus.i_jtag_halt_req = 1;
        bus.i_ex_jump_flag = 1; bus.i_ex_jump_addr = 32'h40;  // still issued
        tick();
        bus.i_ex_jump_flag = 0;
        tick();
        bus.i_ex_hold_req = 0;
        ticks(2);
        bus.i_ex_jump_flag = 1; bus.i_ex_jump_addr = 32'h80;  // masked
        ticks(2);
        bus.i_ex_jump_flag = 0;
        bus.i_jtag_halt_req = 0;
        ticks(2);

        // JTAG reset: single pulse, then a restart mid-sequence.
        bus.i_jtag_reset_req = 1; tick();
        bus.i_jtag_reset_req = 0; ticks(6);
        bus.i_jtag_reset_req = 1; tick();
        bus.i_jtag_reset_req = 0; ticks(1);
        bus.i_jtag_reset_req = 1; tick();
        bus.i_jtag_reset_req = 0; ticks(7);
        // Reset sequence ending while halt is requested.
        bus.i_jtag_halt_req = 1; bus.i_jtag_reset_req = 1; tick();
        bus.i_jtag_reset_req = 0; ticks(6);
        bus.i_jtag_halt_req = 0; ticks(2);

        // Watchdog below and at threshold.
        bus.i_rib_hold_req = 1; ticks(TMO - 1);
        bus.i_rib_hold_req = 0; ticks(3);
        bus.i_rib_hold_req = 1; ticks(TMO + 3);
        bus.i_rib_hold_req = 0; ticks(3);
        rst = 1; tick();
        rst = 0; ticks(2);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bus.i_ex_jump_flag   = ($urandom_range(0, 3) == 0);
            bus.i_ex_jump_addr   = $urandom;
            bus.i_clint_int_flag = ($urandom_range(0, 4) == 0);
            bus.i_clint_int_addr = $urandom;
            bus.i_ex_hold_req    = ($urandom_range(0, 3) == 0);
            bus.i_clint_hold_req = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 5) == 0)  bus.i_rib_hold_req  = ~bus.i_rib_hold_req;
            if ($urandom_range(0, 19) == 0) bus.i_jtag_halt_req = ~bus.i_jtag_halt_req;
            bus.i_jtag_reset_req = ($urandom_range(0, 24) == 0);
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 0;
        idle_inputs();
        ticks(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
